// File: rtl/mcp3202_reader.sv
// Continuous SPI mode-0 reader for an MCP3202: alternates CH0/CH1 and holds the latest sample per channel.
// Latency: 36 + GAP_TICKS + 1 ticks per sample; O_valid appears one I_clk after the DONE tick.
// Backpressure: none; results overwrite in place and O_valid is a fire-and-forget strobe.
module mcp3202_reader #(
    parameter int CLKDIV    = 4,
    parameter int GAP_TICKS = 4,
    parameter bit SGL       = 1'b1
) (
    input  logic        I_clk,
    input  logic        I_reset_n,
    input  logic        I_enable,
    input  logic        I_miso,
    output logic        O_sclk,
    output logic        O_cs_n,
    output logic        O_mosi,
    output logic [11:0] O_ch0,
    output logic [11:0] O_ch1,
    output logic        O_valid,
    output logic        O_valid_ch,
    output logic        O_err,
    output logic        O_busy
);

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_DONE, ST_GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_TICKS - 1);

    state_t      state, state_nxt;
    logic [7:0]  div_cnt;
    logic        tick;
    logic [4:0]  edge_cnt, edge_nxt, edge_inc;
    logic [7:0]  gap_cnt, gap_nxt;
    logic [11:0] sr_dat, sr_nxt;
    logic        err_flag, err_nxt;
    logic        chan, chan_nxt;
    logic        cs_n_nxt, sclk_nxt, mosi_nxt;
    logic        done_vld;

    assign tick     = (div_cnt == DIV_LAST);
    assign edge_inc = edge_cnt + 5'd1;

    always_comb begin
        state_nxt = state;
        edge_nxt  = edge_cnt;
        gap_nxt   = gap_cnt;
        sr_nxt    = sr_dat;
        err_nxt   = err_flag;
        chan_nxt  = chan;
        cs_n_nxt  = O_cs_n;
        sclk_nxt  = O_sclk;
        mosi_nxt  = O_mosi;
        done_vld  = 1'b0;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    cs_n_nxt = 1'b1;
                    sclk_nxt = 1'b0;
                    mosi_nxt = 1'b0;
                    if (I_enable) begin
                        state_nxt = ST_SETUP;
                        cs_n_nxt  = 1'b0;
                        mosi_nxt  = 1'b1;
                        edge_nxt  = 5'd0;
                        err_nxt   = 1'b0;
                    end
                end
                ST_SETUP: state_nxt = ST_SHIFT;
                ST_SHIFT: begin
                    if (!O_sclk) begin
                        // Rising edge: DOUT has been stable since the previous falling edge.
                        sclk_nxt = 1'b1;
                        edge_nxt = edge_inc;
                        if (edge_inc == 5'd5)
                            err_nxt = I_miso;
                        else if (edge_inc >= 5'd6)
                            sr_nxt = {sr_dat[10:0], I_miso};
                    end else begin
                        sclk_nxt = 1'b0;
                        case (edge_cnt)
                            5'd1:    mosi_nxt = SGL;
                            5'd2:    mosi_nxt = chan;
                            5'd3:    mosi_nxt = 1'b1;
                            default: mosi_nxt = 1'b0;
                        endcase
                        if (edge_cnt == 5'd17) begin
                            state_nxt = ST_DONE;
                            cs_n_nxt  = 1'b1;
                            mosi_nxt  = 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    done_vld  = 1'b1;
                    chan_nxt  = ~chan;
                    gap_nxt   = 8'd0;
                    state_nxt = ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state_nxt = ST_IDLE;
                    else
                        gap_nxt = gap_cnt + 8'd1;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state      <= ST_IDLE;
            div_cnt    <= 8'd0;
            edge_cnt   <= 5'd0;
            gap_cnt    <= 8'd0;
            sr_dat     <= 12'd0;
            err_flag   <= 1'b0;
            chan       <= 1'b0;
            O_cs_n     <= 1'b1;
            O_sclk     <= 1'b0;
            O_mosi     <= 1'b0;
            O_ch0      <= 12'd0;
            O_ch1      <= 12'd0;
            O_valid    <= 1'b0;
            O_valid_ch <= 1'b0;
            O_err      <= 1'b0;
            O_busy     <= 1'b0;
        end else begin
            div_cnt  <= tick ? 8'd0 : div_cnt + 8'd1;
            state    <= state_nxt;
            edge_cnt <= edge_nxt;
            gap_cnt  <= gap_nxt;
            sr_dat   <= sr_nxt;
            err_flag <= err_nxt;
            chan     <= chan_nxt;
            O_cs_n   <= cs_n_nxt;
            O_sclk   <= sclk_nxt;
            O_mosi   <= mosi_nxt;
            O_valid  <= done_vld;
            O_err    <= done_vld & err_flag;
            O_busy   <= (state_nxt == ST_SETUP) || (state_nxt == ST_SHIFT) || (state_nxt == ST_DONE);
            if (done_vld) begin
                O_valid_ch <= chan;
                if (chan)
                    O_ch1 <= sr_dat;
                else
                    O_ch0 <= sr_dat;
            end
        end
    end

endmodule

// File: doc/mcp3202_reader.md
# mcp3202_reader

SPI mode-0 master that continuously reads both channels of an MCP3202 12-bit dual-channel ADC, e.g. the analog joystick pots. It is the read-side counterpart of the DAC writer on the vector-output path. It alternates CH0/CH1 conversions, holds the latest result per channel, and pulses a strobe per completed sample. It also flags a missing or stuck-high ADC via the null bit.

## Interface
- CLKDIV, 4: I_clk cycles per SCLK half-period (tick interval); legal range 2..255
- GAP_TICKS, 4: ticks CS_n is held high between conversions; legal range 1..255
- SGL, 1: SGL/DIFF command bit (1 = single-ended)
- I_clk  in  1  system clock; all logic on rising edge
- I_reset_n  in  1  asynchronous active-low reset
- I_enable  in  1  level; 1 = start conversions, 0 = stop after the current one
- I_miso  in  1  ADC DOUT
- O_sclk  out  1  SPI clock, idles low
- O_cs_n  out  1  ADC chip select
- O_mosi  out  1  ADC DIN
- O_ch0  out  12  last CH0 result
- O_ch1  out  12  last CH1 result
- O_valid  out  1  one-I_clk pulse when O_ch0/O_ch1 updates
- O_valid_ch  out  1  channel just updated; meaningful while O_valid=1
- O_err  out  1  one-I_clk pulse, coincident with O_valid, when the null bit was 1
- O_busy  out  1  1 from SETUP through DONE

## Operation
- Tick: divider counts 0..CLKDIV-1. The tick fires on the I_clk where the count equals CLKDIV-1. All FSM actions and SCLK toggles happen on tick cycles only.
- FSM states: IDLE, SETUP, SHIFT, DONE, GAP.
- IDLE: cs_n=1, sclk=0, mosi=0. On a tick with I_enable=1, go to SETUP.
- SETUP: cs_n=0, mosi=1 (start bit), edge counter e=0. Next tick goes to SHIFT.
- SHIFT: sclk toggles each tick, giving 17 rising and 17 falling edges.
  - On rising edge e (1..17), latch I_miso as sampled in that same I_clk cycle.
  - e=5: null bit; store it in an err flag.
  - e=6..17: shift in B11..B0, MSB first.
  - On falling edges: after e=1 drive SGL, after e=2 drive ODD (current channel), after e=3 drive MSBF=1, after e=4 onward drive 0.
  - After falling edge 17, go to DONE.
- DONE (one tick):
  - cs_n=1, sclk=0.
  - Write the shift register to O_ch0 or O_ch1 per the current channel.
  - Pulse O_valid, O_valid_ch and (if err flag) O_err for exactly one I_clk.
  - Toggle the channel and go to GAP.
- GAP: hold cs_n=1 for GAP_TICKS ticks, then go to IDLE.
- Channel starts at 0 after reset and strictly alternates, regardless of I_enable gaps.
- I_enable falling mid-conversion does not abort; the conversion completes and is reported.
- An O_err sample is still stored and reported normally.

## Timing
- Reset values (immediate, asynchronous):
  - O_cs_n=1, O_sclk=0, O_mosi=0.
  - O_ch0=O_ch1=0.
  - O_valid=O_err=O_valid_ch=O_busy=0.
  - FSM=IDLE, channel=0, divider=0.
- Reset mid-conversion: CS rises at once, the partial sample is discarded, and no O_valid is emitted.
- Reset release: the first tick occurs CLKDIV I_clk cycles after the I_reset_n rise.
- Conversion length: 1 (SETUP) + 34 (SHIFT) + 1 (DONE) = 36 ticks of CS-low/active time. CS is low for exactly 35 ticks (SETUP + SHIFT).
- O_valid asserts in the I_clk cycle after the DONE tick edge. Outputs are registered.
- Period with I_enable held high: 36 + GAP_TICKS + 1 (IDLE) ticks.
  - Defaults: 41 ticks = 164 I_clk per sample.
- SCLK frequency = f_I_clk / (2·CLKDIV); the integrator chooses CLKDIV to keep SCLK ≤ the ADC limit.
- CS high ≥ GAP_TICKS+2 ticks. SETUP gives ≥1 tick CS-to-first-SCLK setup.
- O_mosi changes only on SCLK falling ticks (or SETUP). Sampling of I_miso happens only on rising ticks, half a period after the ADC updates DOUT on the falling edge.

## Test plan
- ADC model, CH0 returns 0xA5C, CH1 returns 0x3F1, I_enable=1:
  - First O_valid has O_valid_ch=0 and O_ch0=0xA5C; the next has O_valid_ch=1 and O_ch1=0x3F1.
  - O_err never pulses.
  - Consecutive O_valid pulses are 164 I_clk apart at default parameters.
- MOSI check:
  - Command bits on rising edges 1..4 read 1,1,0,1 for CH0 and 1,1,1,1 for CH1.
  - Exactly 17 SCLK rising edges per CS-low window.
- I_miso tied high: O_ch0=0xFFF and O_err=1 on every O_valid.
- Deassert I_enable at SHIFT edge 8:
  - That conversion completes with a correct value.
  - No further CS fall occurs.
  - Re-enable: the next conversion uses the alternated channel.
- Assert I_reset_n=0 at SHIFT edge 10:
  - All outputs return to reset values without waiting for I_clk.
  - No O_valid is emitted.
  - After release, the first conversion is CH0.
- CLKDIV=2, GAP_TICKS=1: the SCLK period is 4 I_clk and data is still correct with the ADC model's DOUT changing on the falling edge.
